// File: rtl/cordic_wrapper_pkg.sv
// Shared types for the CORDIC wrapper: engine payload types plus the arbiter
// state encoding and default watchdog limit.
package cordic_wrapper_pkg;

    typedef logic [1:0]  cordic_func;
    typedef logic [31:0] cordic_data;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam int CORDIC_ARB_TIMEOUT_DEF = 64;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester after i_ptr, wrapping
// modulo NUM_REQ. Returns one-hot grant, its index and an any-valid flag.
module rr_arbiter #(
    parameter int  NUM_REQ = 4,
    localparam int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [PW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PW-1:0]      o_grant_idx,
    output logic               o_any
);

    logic [PW-1:0] w_idx;
    logic          w_hit;

    // Scan ptr+1 .. ptr+NUM_REQ; the first hit masks every later candidate.
    always_comb begin
        o_grant     = {NUM_REQ{1'b0}};
        o_grant_idx = {PW{1'b0}};
        o_any       = 1'b0;
        w_idx       = {PW{1'b0}};
        w_hit       = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx          = PW'((int'(i_ptr) + k) % NUM_REQ);
            w_hit          = i_valid[w_idx] & ~o_any;
            o_grant[w_idx] = o_grant[w_idx] | w_hit;
            o_grant_idx    = w_hit ? w_idx : o_grant_idx;
            o_any          = o_any | w_hit;
        end
    end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one CORDIC engine between NUM_REQ requesters: round-robin accept,
// single-cycle issue, wait for done (with watchdog), then return the response.
module cordic_arbiter
    import cordic_wrapper_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    parameter int  TIMEOUT = CORDIC_ARB_TIMEOUT_DEF,
    localparam int TO_W    = $clog2(TIMEOUT + 1),
    localparam int PW      = $clog2(NUM_REQ)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic       [NUM_REQ-1:0] i_req_valid,
    input  cordic_func [NUM_REQ-1:0] i_req_func,
    input  cordic_data [NUM_REQ-1:0] i_req_data,
    output logic       [NUM_REQ-1:0] o_req_ready,
    output logic       [NUM_REQ-1:0] o_rsp_valid,
    input  logic       [NUM_REQ-1:0] i_rsp_ready,
    output cordic_data               o_rsp_data,
    output logic                     o_rsp_err,
    output logic                     o_cordic_valid,
    output cordic_func               o_cordic_func,
    output cordic_data               o_cordic_data,
    input  logic                     i_cordic_done,
    input  cordic_data               i_cordic_data,
    output logic                     o_busy,
    output logic                     o_spurious
);

    arb_state_e          r_state;
    arb_state_e          w_next;
    logic [PW-1:0]       r_rr_ptr;
    logic [PW-1:0]       r_owner;
    logic [TO_W-1:0]     r_wd;
    logic [NUM_REQ-1:0]  r_rsp_valid;
    cordic_data          r_rsp_data;
    logic                r_rsp_err;
    logic                r_cordic_valid;
    cordic_func          r_cordic_func;
    cordic_data          r_cordic_data;
    logic                r_spurious;

    logic [NUM_REQ-1:0]  w_grant;
    logic [PW-1:0]       w_grant_idx;
    logic                w_any;
    logic                w_timeout;
    logic [NUM_REQ-1:0]  w_owner_oh;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_valid     (i_req_valid),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_any)
    );

    assign w_timeout  = (r_wd == TO_W'(TIMEOUT - 1));
    assign w_owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; done takes priority over the watchdog expiring.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_any ? ISSUE : IDLE;
            ISSUE:   w_next = WAIT;
            WAIT: begin
                if (i_cordic_done) begin
                    w_next = RESP;
                end else if (w_timeout) begin
                    w_next = RESP;
                end else begin
                    w_next = WAIT;
                end
            end
            RESP:    w_next = i_rsp_ready[r_owner] ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    // Ready is held low while reset is asserted so nothing appears accepted.
    always_comb begin
        o_req_ready = {NUM_REQ{1'b0}};
        if ((r_state == IDLE) && i_rst) begin
            o_req_ready = w_grant;
        end else begin
            o_req_ready = {NUM_REQ{1'b0}};
        end
    end

    // Payload, watchdog and pointer registers. The watchdog counts cycles
    // since the issue pulse, so the ISSUE cycle itself is already cycle 1.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rr_ptr       <= PW'(NUM_REQ - 1);
            r_owner        <= {PW{1'b0}};
            r_wd           <= {TO_W{1'b0}};
            r_rsp_valid    <= {NUM_REQ{1'b0}};
            r_rsp_data     <= 32'd0;
            r_rsp_err      <= 1'b0;
            r_cordic_valid <= 1'b0;
            r_cordic_func  <= 2'd0;
            r_cordic_data  <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_owner        <= w_grant_idx;
                        r_cordic_func  <= i_req_func[w_grant_idx];
                        r_cordic_data  <= i_req_data[w_grant_idx];
                        r_cordic_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    r_cordic_valid <= 1'b0;
                    r_wd           <= TO_W'(1);
                end
                WAIT: begin
                    if (i_cordic_done) begin
                        r_rsp_data  <= i_cordic_data;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= w_owner_oh;
                    end else if (w_timeout) begin
                        r_rsp_data  <= 32'd0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= w_owner_oh;
                    end else begin
                        r_wd <= r_wd + TO_W'(1);
                    end
                end
                RESP: begin
                    if (i_rsp_ready[r_owner]) begin
                        r_rsp_valid <= {NUM_REQ{1'b0}};
                        r_rr_ptr    <= r_owner;
                    end
                end
                default: begin
                    r_cordic_valid <= 1'b0;
                end
            endcase
        end
    end

    // Sticky flag for an engine done that arrives when nothing is pending.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_spurious <= 1'b0;
        end else if (i_cordic_done && (r_state != WAIT)) begin
            r_spurious <= 1'b1;
        end
    end

    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_data     = r_rsp_data;
    assign o_rsp_err      = r_rsp_err;
    assign o_cordic_valid = r_cordic_valid;
    assign o_cordic_func  = r_cordic_func;
    assign o_cordic_data  = r_cordic_data;
    assign o_busy         = (r_state != IDLE);
    assign o_spurious     = r_spurious;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Scoreboard bench for cordic_arbiter with a fixed-latency engine model.
module tb_cordic_arbiter;
    import cordic_wrapper_pkg::*;

    localparam int N   = 4;
    localparam int TO  = 64;
    localparam int LAT = 14;

    logic             clk;
    logic             rst_n;
    logic       [N-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
    cordic_func [N-1:0] req_func;
    cordic_data [N-1:0] req_data;
    cordic_data       rsp_data;
    logic             rsp_err;
    logic             c_valid;
    cordic_func       c_func;
    cordic_data       c_data;
    logic             c_done;
    cordic_data       c_rdata;
    logic             busy, spurious;

    logic       eng_done  = 1'b0;
    logic       man_done  = 1'b0;
    cordic_data eng_rdata = 32'd0;
    cordic_data man_data  = 32'd0;
    cordic_func eng_f     = 2'd0;
    cordic_data eng_d     = 32'd0;
    int         eng_mode  = 0;
    int         eng_cnt   = 0;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    typedef struct {
        int         owner;
        cordic_data data;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   order_q[$];
    exp_t mon_e;
    logic [N-1:0] mon_acc;

    assign c_done  = eng_done | man_done;
    assign c_rdata = man_done ? man_data : eng_rdata;

    cordic_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .i_clk          (clk),
        .i_rst          (rst_n),
        .i_req_valid    (req_valid),
        .i_req_func     (req_func),
        .i_req_data     (req_data),
        .o_req_ready    (req_ready),
        .o_rsp_valid    (rsp_valid),
        .i_rsp_ready    (rsp_ready),
        .o_rsp_data     (rsp_data),
        .o_rsp_err      (rsp_err),
        .o_cordic_valid (c_valid),
        .o_cordic_func  (c_func),
        .o_cordic_data  (c_data),
        .i_cordic_done  (c_done),
        .i_cordic_data  (c_rdata),
        .o_busy         (busy),
        .o_spurious     (spurious)
    );

    function automatic cordic_data model(input cordic_func f, input cordic_data d);
        return ({d[15:0], d[31:16]} ^ 32'hA5A5_0000) + {30'd0, f};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: done pulse LAT cycles after the issue cycle (mode 0 only).
    always begin
        @(posedge clk);
        #1;
        eng_done = 1'b0;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                eng_done  = 1'b1;
                eng_rdata = model(eng_f, eng_d);
            end
        end
        if (c_valid && eng_mode == 0) begin
            eng_cnt = LAT;
            eng_f   = c_func;
            eng_d   = c_data;
        end
    end

    // Monitor: push expectations on accept, compare on response handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            mon_acc = req_ready & req_valid;
            if (req_ready != 4'b0000)
                check_eq("req_ready_onehot", 64'($onehot(req_ready)), 64'(1));
            for (int i = 0; i < N; i++) begin
                if (mon_acc[i]) begin
                    mon_e.owner = i;
                    case (eng_mode)
                        0:       begin mon_e.data = model(req_func[i], req_data[i]); mon_e.err = 1'b0; end
                        1:       begin mon_e.data = 32'd0; mon_e.err = 1'b1; end
                        default: begin mon_e.data = man_data; mon_e.err = 1'b0; end
                    endcase
                    sb.push_back(mon_e);
                    grant_log.push_back(i);
                end
            end
            if (rsp_valid != 4'b0000) begin
                check_eq("rsp_valid_onehot", 64'($onehot(rsp_valid)), 64'(1));
                if ((rsp_valid & rsp_ready) != 4'b0000) begin
                    check_eq("sb_nonempty", 64'(sb.size() != 0), 64'(1));
                    if (sb.size() != 0) begin
                        mon_e = sb.pop_front();
                        check_eq("rsp_owner", 64'(rsp_valid), 64'(N'(1) << mon_e.owner));
                        check_eq("rsp_data", 64'(rsp_data), 64'(mon_e.data));
                        check_eq("rsp_err", 64'(rsp_err), 64'(mon_e.err));
                    end
                end
            end
        end
    end

    task automatic wait_rsp(input int budget, output int t);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rsp_valid != 4'b0000) begin
                found = 1'b1;
                break;
            end
        end
        t = cyc;
        check_eq("wait_rsp_bound", 64'(found), 64'(1));
    endtask

    task automatic wait_idle(input int budget);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("wait_idle_bound", 64'(found), 64'(1));
        tick();
    endtask

    // Consume accepts: either refill the granted requester or drop its valid.
    task automatic service(input int max_g, input int budget, input bit refill);
        int ng;
        bit done_f;
        ng = 0;
        done_f = 1'b0;
        grant_log.delete();
        order_q.delete();
        for (int c = 0; c < budget && !done_f; c++) begin
            tick();
            while (grant_log.size() > 0) begin
                int g;
                g = grant_log.pop_front();
                order_q.push_back(g);
                ng++;
                if (refill) req_data[g] = req_data[g] + 32'h11;
                else        req_valid[g] = 1'b0;
                if (ng >= max_g) req_valid = 4'b0000;
            end
            if (ng >= max_g) done_f = 1'b1;
        end
        check_eq("service_bound", 64'(done_f), 64'(1));
        req_valid = 4'b0000;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, 64'(busy), 64'(0));
        check_eq({tag, "_spurious"}, 64'(spurious), 64'(0));
        check_eq({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        check_eq({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        check_eq({tag, "_cvalid"}, 64'(c_valid), 64'(0));
        check_eq({tag, "_cfunc"}, 64'(c_func), 64'(0));
        check_eq({tag, "_cdata"}, 64'(c_data), 64'(0));
        check_eq({tag, "_rsp_err"}, 64'(rsp_err), 64'(0));
        check_eq({tag, "_rsp_data"}, 64'(rsp_data), 64'(0));
    endtask

    initial begin
        int t0, t1;
        rst_n = 1'b0; req_valid = 4'b0000; rsp_ready = 4'b1111;
        for (int i = 0; i < N; i++) begin req_func[i] = 2'd0; req_data[i] = 32'd0; end
        #1;
        check_all_zero("reset");
        #21 rst_n = 1'b1;
        tick();

        // Single op on requester 2.
        req_func[2] = 2'd0; req_data[2] = 32'h1234; req_valid[2] = 1'b1;
        @(negedge clk);
        check_eq("t1_req_ready", 64'(req_ready), 64'(4'b0100));
        tick();
        req_valid[2] = 1'b0;
        @(negedge clk);
        check_eq("t1_cvalid", 64'(c_valid), 64'(1));
        check_eq("t1_cdata", 64'(c_data), 64'(32'h1234));
        check_eq("t1_busy", 64'(busy), 64'(1));
        t0 = cyc;
        @(negedge clk);
        check_eq("t1_cvalid_pulse", 64'(c_valid), 64'(0));
        wait_rsp(200, t1);
        check_eq("t1_rsp_lat", 64'(t1 - t0), 64'(LAT + 1));
        check_eq("t1_rsp_owner", 64'(rsp_valid), 64'(4'b0100));
        wait_idle(100);

        // Round-robin with all requesters valid, after a fresh reset.
        @(posedge clk); #2 rst_n = 1'b0; #5 rst_n = 1'b1; sb.delete();
        tick();
        for (int i = 0; i < N; i++) begin
            req_func[i] = 2'(i); req_data[i] = 32'h1000 * (i + 1);
        end
        req_valid = 4'b1111;
        service(6, 400, 1'b1);
        check_eq("rr_count", 64'(order_q.size()), 64'(6));
        for (int k = 0; k < 6 && k < order_q.size(); k++)
            check_eq("rr_order", 64'(order_q[k]), 64'(k % N));
        wait_idle(200);

        // Backpressure on requester 1 while 0 and 3 wait.
        rsp_ready = 4'b1101;
        req_func[1] = 2'd1; req_data[1] = 32'hCAFE_0001; req_valid[1] = 1'b1;
        service(1, 100, 1'b0);
        req_func[0] = 2'd2; req_data[0] = 32'h0000_0A0A; req_valid[0] = 1'b1;
        req_func[3] = 2'd3; req_data[3] = 32'h3333_0003; req_valid[3] = 1'b1;
        wait_rsp(100, t1);
        for (int i = 0; i < 20; i++) begin
            check_eq("bp_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
            check_eq("bp_rsp_data", 64'(rsp_data), 64'(model(2'd1, 32'hCAFE_0001)));
            check_eq("bp_rsp_err", 64'(rsp_err), 64'(0));
            check_eq("bp_req_ready", 64'(req_ready), 64'(0));
            @(negedge clk);
        end
        tick();
        rsp_ready = 4'b1111;
        req_valid[0] = 1'b1; req_valid[3] = 1'b1;
        service(2, 300, 1'b0);
        check_eq("bp_next_a", 64'(order_q.size() > 0 ? order_q[0] : -1), 64'(3));
        check_eq("bp_next_b", 64'(order_q.size() > 1 ? order_q[1] : -1), 64'(0));
        wait_idle(200);

        // Engine never answers: watchdog abort after TIMEOUT cycles.
        eng_mode = 1;
        req_func[2] = 2'd1; req_data[2] = 32'h2222; req_valid[2] = 1'b1;
        service(1, 100, 1'b0);
        @(negedge clk);
        check_eq("to_cvalid", 64'(c_valid), 64'(1));
        t0 = cyc;
        wait_rsp(200, t1);
        check_eq("to_lat", 64'(t1 - t0), 64'(TO));
        check_eq("to_err", 64'(rsp_err), 64'(1));
        check_eq("to_data", 64'(rsp_data), 64'(0));
        wait_idle(50);
        eng_mode = 0;
        req_func[3] = 2'd1; req_data[3] = 32'h4444; req_valid[3] = 1'b1;
        service(1, 100, 1'b0);
        wait_idle(100);

        // Spurious done in IDLE.
        check_eq("sp_before", 64'(spurious), 64'(0));
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        @(negedge clk);
        check_eq("sp_set", 64'(spurious), 64'(1));
        check_eq("sp_idle", 64'(busy), 64'(0));
        repeat (5) @(negedge clk);
        check_eq("sp_sticky", 64'(spurious), 64'(1));
        tick();

        // Done on the watchdog's last cycle still wins.
        eng_mode = 2; man_data = 32'hDEAD_BEEF;
        req_func[0] = 2'd2; req_data[0] = 32'h5; req_valid[0] = 1'b1;
        service(1, 100, 1'b0);
        @(negedge clk);
        t0 = cyc;
        repeat (TO - 1) @(posedge clk);
        #1 man_done = 1'b1;
        tick();
        man_done = 1'b0;
        wait_rsp(50, t1);
        check_eq("edge_lat", 64'(t1 - t0), 64'(TO));
        check_eq("edge_err", 64'(rsp_err), 64'(0));
        check_eq("edge_data", 64'(rsp_data), 64'(32'hDEAD_BEEF));
        wait_idle(50);
        eng_mode = 0;

        // Async reset while waiting on the engine.
        req_func[2] = 2'd3; req_data[2] = 32'h7777; req_valid[2] = 1'b1;
        service(1, 100, 1'b0);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("arst");
        #4 rst_n = 1'b1;
        sb.delete();
        repeat (15) @(negedge clk);
        check_eq("arst_late_done", 64'(spurious), 64'(1));
        check_eq("arst_idle", 64'(busy), 64'(0));
        tick();
        req_data[0] = 32'h0101; req_data[2] = 32'h0202;
        req_valid[0] = 1'b1; req_valid[2] = 1'b1;
        service(2, 300, 1'b0);
        check_eq("arst_first", 64'(order_q.size() > 0 ? order_q[0] : -1), 64'(0));
        check_eq("arst_second", 64'(order_q.size() > 1 ? order_q[1] : -1), 64'(2));
        wait_idle(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
